// File: rtl/fetch_pkg.sv
// Shared widths, defaults and the instruction-queue entry type for the fetch stage.
package fetch_pkg;

    localparam int ADDR_W        = 64;
    localparam int INSTR_W       = 32;
    localparam int DEFAULT_DEPTH = 4;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue between memory responses and the datapath.
// A flush empties the queue in one edge and wins over any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     push_entry,
    output fetch_entry_t     head_entry,
    output logic             valid,
    output logic [CNT_W-1:0] occupancy
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !flush && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    assign valid      = (count != '0);
    assign head_entry = valid ? mem[rd_ptr] : '0;
    assign occupancy  = count;

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch with single-outstanding memory request and redirect flush.
// Holds fetch_pc and the in-flight flag; queueing lives in fetch_fifo.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int                DEPTH    = DEFAULT_DEPTH
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic                        imem_req,
    output logic [ADDR_W-1:0]           imem_addr,
    input  logic [INSTR_W-1:0]          imem_rdata,
    input  logic                        redirect_valid,
    input  logic [ADDR_W-1:0]           redirect_pc,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ADDR_W-1:0]           out_pc,
    output logic [INSTR_W-1:0]          out_instr,
    output logic [$clog2(DEPTH+1)-1:0]  occupancy
);

    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight;
    logic              room;
    logic              push;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head_entry;

    // Counting the in-flight word as occupied guarantees its push always finds a free slot.
    assign room      = (32'(occupancy) + 32'(inflight)) < DEPTH;
    assign imem_req  = rst && !redirect_valid && room;
    assign imem_addr = fetch_pc;

    assign push             = inflight && !redirect_valid;
    assign pop              = out_valid && out_ready;
    assign push_entry.pc    = inflight_pc;
    assign push_entry.instr = imem_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) inflight_pc <= fetch_pc;
            if (redirect_valid)  fetch_pc <= redirect_pc;
            else if (imem_req)   fetch_pc <= fetch_pc + ADDR_W'(4);
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .flush      (redirect_valid),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .valid      (out_valid),
        .occupancy  (occupancy)
    );

    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed vector table, reset/wrap sequences and randomized run against a queue-based fetch model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFF8;

    typedef struct {
        logic        ready;
        logic        rv;
        logic [63:0] rpc;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
        int          exp_occ;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  occupancy;

    logic        w_rst;
    logic        w_req;
    logic [63:0] w_addr;
    logic [31:0] w_rdata;
    logic        w_rv;
    logic [63:0] w_rpc;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_pc;
    logic [31:0] w_instr;
    logic [2:0]  w_occ;

    int passed = 0;
    int total  = 0;

    logic [63:0] q[$];
    logic        m_inflight;
    logic [63:0] m_inflight_pc;
    logic [63:0] m_fetch_pc;
    logic [63:0] next_out_pc;
    logic        pend_v;
    logic [63:0] pend_a;

    vec_t vecs[24];

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .occupancy      (occupancy)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .DEPTH(4)) dut_wrap (
        .clk            (clk),
        .rst            (w_rst),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_rdata     (w_rdata),
        .redirect_valid (w_rv),
        .redirect_pc    (w_rpc),
        .out_valid      (w_valid),
        .out_ready      (w_ready),
        .out_pc         (w_pc),
        .out_instr      (w_instr),
        .occupancy      (w_occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents are derived from the address so every word identifies its PC.
    function automatic logic [31:0] word_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic vec_t mk(input logic ready, input logic rv, input logic [63:0] rpc,
                                input logic req, input logic [63:0] addr, input logic vld,
                                input logic [63:0] pc, input int occ);
        vec_t v;
        v.ready = ready; v.rv = rv; v.rpc = rpc;
        v.exp_req = req; v.exp_addr = addr; v.exp_valid = vld; v.exp_pc = pc; v.exp_occ = occ;
        return v;
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        q.delete();
        m_inflight    = 1'b0;
        m_inflight_pc = '0;
        m_fetch_pc    = 64'h0;
        next_out_pc   = 64'h0;
    endtask

    task automatic check_reset_outputs();
        check_output("rst_imem_req", imem_req, 0);
        check_output("rst_imem_addr", imem_addr, 64'h0);
        check_output("rst_out_valid", out_valid, 0);
        check_output("rst_out_pc", out_pc, 64'h0);
        check_output("rst_out_instr", out_instr, 32'h0);
        check_output("rst_occupancy", occupancy, 0);
    endtask

    // One clock cycle: drive memory response and inputs at negedge, check, advance the model.
    task automatic apply_stimulus(input logic ready, input logic rv, input logic [63:0] rpc);
        logic        exp_req;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_instr;
        int          occ;
        @(negedge clk);
        imem_rdata     = pend_v ? word_of(pend_a) : $urandom;
        out_ready      = ready;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        occ       = q.size();
        exp_req   = rst && !rv && ((occ + int'(m_inflight)) < 4);
        exp_valid = (occ != 0);
        exp_pc    = exp_valid ? q[0] : 64'h0;
        exp_instr = exp_valid ? word_of(q[0]) : 32'h0;
        check_output("imem_req", imem_req, exp_req);
        check_output("imem_addr", imem_addr, m_fetch_pc);
        check_output("out_valid", out_valid, exp_valid);
        check_output("out_pc", out_pc, exp_pc);
        check_output("out_instr", out_instr, exp_instr);
        check_output("occupancy", occupancy, 64'(occ));
        if (out_valid && ready) begin
            check_output("program_order", out_pc, next_out_pc);
            next_out_pc = next_out_pc + 64'd4;
        end
        pend_v = imem_req;
        pend_a = imem_addr;
        if (exp_valid && ready) void'(q.pop_front());
        if (rv) begin
            q.delete();
            m_inflight  = 1'b0;
            m_fetch_pc  = rpc;
            next_out_pc = rpc;
        end else begin
            if (m_inflight) q.push_back(m_inflight_pc);
            m_inflight    = exp_req;
            m_inflight_pc = m_fetch_pc;
            if (exp_req) m_fetch_pc = m_fetch_pc + 64'd4;
        end
    endtask

    // Reset pulse strictly between clock edges; outputs must clear without a clock edge.
    task automatic reset_pulse();
        @(posedge clk);
        #2 rst = 1'b0;
        #1 check_reset_outputs();
        #1 rst = 1'b1;
        model_reset();
    endtask

    task automatic wrap_sequence();
        logic        wv;
        logic [63:0] wa;
        logic [63:0] exp_addr;
        logic [63:0] exp_pc;
        wv = 1'b0;
        wa = '0;
        @(posedge clk);
        #2 w_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            w_rdata = wv ? word_of(wa) : 32'h0;
            #1;
            exp_addr = WRAP_PC + 64'(4 * i);
            check_output("wrap_req", w_req, 1);
            check_output("wrap_addr", w_addr, exp_addr);
            if (i >= 2) begin
                exp_pc = WRAP_PC + 64'(4 * (i - 2));
                check_output("wrap_out_pc", w_pc, exp_pc);
                check_output("wrap_out_instr", w_instr, word_of(exp_pc));
            end
            wv = w_req;
            wa = w_addr;
        end
    endtask

    initial begin
        logic        ready;
        logic        rv;
        logic [63:0] rpc;

        vecs[0]  = mk(1, 0, 0, 1, 64'h00, 0, 64'h00, 0);
        vecs[1]  = mk(1, 0, 0, 1, 64'h04, 0, 64'h00, 0);
        vecs[2]  = mk(1, 0, 0, 1, 64'h08, 1, 64'h00, 1);
        vecs[3]  = mk(1, 0, 0, 1, 64'h0C, 1, 64'h04, 1);
        vecs[4]  = mk(0, 0, 0, 1, 64'h10, 1, 64'h08, 1);
        vecs[5]  = mk(0, 0, 0, 1, 64'h14, 1, 64'h08, 2);
        vecs[6]  = mk(0, 0, 0, 0, 64'h18, 1, 64'h08, 3);
        for (int i = 7; i < 14; i++) vecs[i] = mk(0, 0, 0, 0, 64'h18, 1, 64'h08, 4);
        vecs[14] = mk(1, 0, 0, 0, 64'h18, 1, 64'h08, 4);
        vecs[15] = mk(1, 0, 0, 1, 64'h18, 1, 64'h0C, 3);
        vecs[16] = mk(1, 0, 0, 1, 64'h1C, 1, 64'h10, 2);
        vecs[17] = mk(1, 0, 0, 1, 64'h20, 1, 64'h14, 2);
        vecs[18] = mk(0, 0, 0, 1, 64'h24, 1, 64'h18, 2);
        vecs[19] = mk(1, 1, 64'h100, 0, 64'h28, 1, 64'h18, 3);
        vecs[20] = mk(1, 0, 0, 1, 64'h100, 0, 64'h00, 0);
        vecs[21] = mk(1, 0, 0, 1, 64'h104, 0, 64'h00, 0);
        vecs[22] = mk(1, 0, 0, 1, 64'h108, 1, 64'h100, 1);
        vecs[23] = mk(1, 0, 0, 1, 64'h10C, 1, 64'h104, 1);

        rst            = 1'b0;
        w_rst          = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        w_rdata        = '0;
        w_rv           = 1'b0;
        w_rpc          = '0;
        w_ready        = 1'b1;
        pend_v         = 1'b0;
        pend_a         = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #2 check_reset_outputs();
        #1 rst = 1'b1;

        for (int i = 0; i < 24; i++) begin
            apply_stimulus(vecs[i].ready, vecs[i].rv, vecs[i].rpc);
            check_output($sformatf("vec%0d_req", i), imem_req, vecs[i].exp_req);
            check_output($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            check_output($sformatf("vec%0d_valid", i), out_valid, vecs[i].exp_valid);
            check_output($sformatf("vec%0d_pc", i), out_pc, vecs[i].exp_pc);
            check_output($sformatf("vec%0d_occ", i), occupancy, 64'(vecs[i].exp_occ));
        end

        // A request went out in the last table cycle, so its response is pending here.
        reset_pulse();
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b0, 64'h0);
        check_output("restart_out_pc", out_pc, 64'h4);

        for (int i = 0; i < 3000; i++) begin
            ready = ($urandom_range(0, 9) < 7);
            rv    = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 3) * 4);
            else                           rpc = {$urandom, $urandom} & ~64'h3;
            apply_stimulus(ready, rv, rv ? rpc : 64'h0);
            if (i % 700 == 350) reset_pulse();
        end

        wrap_sequence();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameters: RESET_PC, 64'h0, first fetch address after reset; DEPTH, 4, instruction queue entries (power of two).
REQ-002 Port list, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- imem_req  out  1  fetch request to instruction memory this cycle.
- imem_addr  out  64  byte address of the request.
- imem_rdata  in  32  instruction word, valid exactly one cycle after imem_req.
- redirect_valid  in  1  taken branch/unconditional branch from the datapath.
- redirect_pc  in  64  branch target address.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  datapath accepts the head this cycle.
- out_pc  out  64  PC of the head instruction.
- out_instr  out  32  head instruction word.
- occupancy  out  3  current number of queue entries, 0..DEPTH.

Function
REQ-003 The fetch_pc register SHALL hold the next address to request; imem_addr SHALL equal fetch_pc.
REQ-004 imem_req SHALL be 1 iff not in reset, redirect_valid=0, and occupancy + inflight < DEPTH. inflight is a 1-bit flag meaning a response is due next cycle.
REQ-005 On every cycle with imem_req=1, fetch_pc SHALL advance by 4 with modulo-2^64 wrap. For example, 64'hFFFF_FFFF_FFFF_FFFC advances to 0.
REQ-006 inflight SHALL be set in the cycle after a request and cleared otherwise. The request PC SHALL be captured alongside inflight.
REQ-007 In the inflight cycle, {captured PC, imem_rdata} SHALL be pushed at the queue tail unless discarded per REQ-010.
REQ-008 A transfer SHALL occur iff out_valid & out_ready, popping the head. out_valid SHALL equal (occupancy != 0). out_pc/out_instr SHALL show the head entry, and 0 when empty.
REQ-009 A simultaneous push and pop SHALL leave occupancy unchanged. Pointers SHALL wrap modulo DEPTH. A push when full SHALL be impossible by REQ-004.
REQ-010 redirect_valid=1 in cycle N SHALL cause the following:
- A transfer in cycle N is still honoured.
- All remaining entries are flushed at the N edge.
- fetch_pc is loaded with redirect_pc at the N edge.
- No request is issued in N.
- Any response arriving in N+1 is discarded.
- The first request, for redirect_pc, is issued in N+1.
REQ-011 Redirect SHALL take priority over the PC increment and over the push.
REQ-012 Request-to-out_valid latency SHALL be 2 cycles (request N, data N+1, out_valid N+2).
REQ-013 With out_ready held at 1, sustained throughput SHALL be one instruction per cycle.
REQ-014 Order SHALL be strict program order. No entry SHALL be duplicated or dropped except by flush.

Reset
REQ-015 rst=0 SHALL asynchronously force the following, regardless of clk: fetch_pc=RESET_PC, inflight=0, occupancy=0, pointers=0, imem_req=0, out_valid=0, out_pc=0, out_instr=0.
REQ-016 Reset asserted mid-operation SHALL discard queued and in-flight instructions. A response arriving after reset release SHALL NOT be pushed.
REQ-017 The first request SHALL be issued in the first clock cycle after rst deasserts, with imem_addr=RESET_PC.

Structure
REQ-018 Package fetch_pkg SHALL hold:
- ADDR_W=64 and INSTR_W=32.
- Default DEPTH and RESET_PC.
- The queue entry typedef {pc[63:0], instr[31:0]}.
REQ-019 Queue storage, pointers and occupancy SHALL be one sub-module, fetch_fifo, with push/pop/flush inputs. fetch_unit SHALL hold fetch_pc, the inflight flag and the request/redirect logic.

Verification
REQ-020 Reset release, out_ready=1, memory returning addr-derived words -> imem_addr 0,4,8,... each cycle. out_valid first at cycle 2 with out_pc=0, then one instruction per cycle.
REQ-021 out_ready=0 for 10 cycles -> occupancy reaches 4 and imem_req drops. After out_ready=1, entries PC 0,4,8,12 drain in order with no loss.
REQ-022 redirect_valid=1, redirect_pc=0x100 with 3 entries queued and a response in flight -> the head transfer that cycle is honoured. Occupancy is 0 next cycle and the in-flight word is dropped. imem_addr=0x100 in N+1, and out_pc=0x100 in N+3.
REQ-023 RESET_PC=64'hFFFF_FFFF_FFFF_FFF8 -> requests FFF8, FFFC, 0, 4. out_pc follows the same wrap.
REQ-024 rst pulsed low mid-stream, asynchronously between edges, with a response pending -> outputs clear immediately and the pending word is never output. Fetch restarts at RESET_PC.
REQ-025 Random out_ready plus random redirects, compared against a reference PC-sequence model -> no duplicate, dropped or reordered instruction, and occupancy never exceeds 4.
